// File: rtl/dec_pkg.sv
// Shared types and elaboration helpers for the posit decode path.
package dec_pkg;

  typedef enum logic {
    LZC_ZEROS = 1'b0,
    LZC_ONES  = 1'b1
  } lzc_mode_e;

  function automatic int lzc_levels(input int width);
    return $clog2(width);
  endfunction

  // Tree level whose outputs are registered by stage k (ceil(k*levels/stages)).
  function automatic int lzc_cut(input int k, input int levels, input int stages);
    return (k * levels + stages - 32'sd1) / stages;
  endfunction

  // Stage that registers a given tree level, or 0 when the level stays combinational.
  function automatic int lzc_stage_of(input int level, input int levels, input int stages);
    int s;
    s = 32'sd0;
    for (int k = 1; k <= stages; k++) begin
      if (lzc_cut(k, levels, stages) == level) begin
        s = k;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/lzc_node.sv
// Merges two child leading-zero results (found flag, count) into their parent.
module lzc_node #(
  parameter int CW = 1
) (
  input  logic          vld_h_i,
  input  logic [CW-1:0] cnt_h_i,
  input  logic          vld_l_i,
  input  logic [CW-1:0] cnt_l_i,
  output logic          vld_o,
  output logic [CW:0]   cnt_o
);

  assign vld_o = vld_h_i | vld_l_i;
  // A one in the high half decides the count; otherwise the whole high half is zeros.
  assign cnt_o = vld_h_i ? {1'b0, cnt_h_i} : {vld_l_i, cnt_l_i};

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading-zero / leading-one counter with elastic valid/ready stages
// and a sideband tag; pipeline cuts are spread evenly over the counting tree.
module lzc_pipe
  import dec_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  parameter  int TAG_W  = 4,
  localparam int CNT_W  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_all,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = lzc_levels(WIDTH);

  logic [STAGES:1]            v_q, v_d, ld_s, en_s;
  logic [STAGES:1][TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]           out_cnt_q;
  logic                       out_all_q;
  logic [WIDTH-1:0]           op_s;

  // Load terms: a stage loads when empty or when everything downstream can move.
  always_comb begin
    logic nxt;
    nxt  = out_ready;
    ld_s = '0;
    for (int k = STAGES; k >= 1; k--) begin
      ld_s[k] = ~v_q[k] | nxt;
      nxt     = ld_s[k];
    end
  end

  assign in_ready = rst_n & ld_s[1];

  // Next valid/tag: each loading stage takes its upstream neighbour's content.
  always_comb begin
    logic             prev_v;
    logic [TAG_W-1:0] prev_t;
    prev_v = in_valid;
    prev_t = in_tag;
    v_d    = v_q;
    tag_d  = tag_q;
    en_s   = '0;
    for (int k = 1; k <= STAGES; k++) begin
      en_s[k] = ld_s[k] & prev_v;
      if (ld_s[k]) v_d[k] = prev_v;
      else         v_d[k] = v_q[k];
      if (en_s[k]) tag_d[k] = prev_t;
      else         tag_d[k] = tag_q[k];
      prev_v = v_q[k];
      prev_t = tag_q[k];
    end
  end

  // Stage valid and tag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      tag_q <= '0;
    end else begin
      v_q   <= v_d;
      tag_q <= tag_d;
    end
  end

  // Leading ones are counted as leading zeros of the inverted operand.
  assign op_s = (lzc_mode_e'(in_mode) == LZC_ONES) ? ~in_data : in_data;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int N = WIDTH >> l;
    logic [N-1:0]   node_vld_s;
    logic [N*l-1:0] node_cnt_s;

    if (l == 1) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_n
        assign node_vld_s[i] = op_s[2*i+1] | op_s[2*i];
        assign node_cnt_s[i] = ~op_s[2*i+1] & op_s[2*i];
      end
    end else begin : g_mrg
      for (genvar i = 0; i < N; i++) begin : g_n
        lzc_node #(.CW(l-1)) u_node (
          .vld_h_i (g_lvl[l-1].g_fwd.fwd_vld[2*i+1]),
          .cnt_h_i (g_lvl[l-1].g_fwd.fwd_cnt[(2*i+1)*(l-1) +: (l-1)]),
          .vld_l_i (g_lvl[l-1].g_fwd.fwd_vld[2*i]),
          .cnt_l_i (g_lvl[l-1].g_fwd.fwd_cnt[(2*i)*(l-1) +: (l-1)]),
          .vld_o   (node_vld_s[i]),
          .cnt_o   (node_cnt_s[i*l +: l])
        );
      end
    end

    if (l < LEVELS) begin : g_fwd
      localparam int SK = lzc_stage_of(l, LEVELS, STAGES);
      logic [N-1:0]   fwd_vld;
      logic [N*l-1:0] fwd_cnt;
      if (SK != 0) begin : g_reg
        // Pipeline cut after this level.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            fwd_vld <= '0;
            fwd_cnt <= '0;
          end else if (en_s[SK]) begin
            fwd_vld <= node_vld_s;
            fwd_cnt <= node_cnt_s;
          end
        end
      end else begin : g_wire
        assign fwd_vld = node_vld_s;
        assign fwd_cnt = node_cnt_s;
      end
    end else begin : g_root
      logic [CNT_W-1:0] cnt_d;
      logic             all_d;
      assign all_d = ~node_vld_s[0];
      assign cnt_d = node_vld_s[0] ? {1'b0, node_cnt_s} : CNT_W'(WIDTH);
      // Final stage holds the formatted result so outputs come from flops.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_cnt_q <= '0;
          out_all_q <= 1'b0;
        end else if (en_s[STAGES]) begin
          out_cnt_q <= cnt_d;
          out_all_q <= all_d;
        end
      end
    end
  end

  assign out_valid = v_q[STAGES];
  assign out_tag   = tag_q[STAGES];
  assign out_cnt   = out_cnt_q;
  assign out_all   = out_all_q;

endmodule

// File: tb/tb_lzc_pipe.sv
// Scoreboard bench for lzc_pipe: directed + random traffic on the default
// configuration, plus latency/result checks on other WIDTH/STAGES builds.
module tb_lzc_pipe;

  localparam int W0  = 32;
  localparam int S0  = 2;
  localparam int CW0 = 6;

  typedef struct {
    logic [CW0-1:0] cnt;
    logic           all;
    logic [3:0]     tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, in_valid, in_ready, in_mode, out_valid, out_ready, out_all;
  logic [W0-1:0]  in_data;
  logic [3:0]     in_tag, out_tag;
  logic [CW0-1:0] out_cnt;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cfg_done = 0;
  bit   rand_rdy = 1'b0;
  exp_t sbq[$];

  lzc_pipe #(.WIDTH(W0), .STAGES(S0), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
    .out_all(out_all), .out_tag(out_tag)
  );

  // Reference: walk down from the MSB while bits equal the counted value.
  function automatic int ref_lzc(input logic [63:0] d, input logic m, input int w);
    int n;
    n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i] != m) break;
      n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Offer one operand; push its expected result when the handshake is seen.
  task automatic send(input logic [31:0] d, input logic m, input logic [3:0] t,
                      input int ecnt, output int waits);
    exp_t e;
    waits = 0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout tag %0d never accepted", t);
    end else begin
      e.cnt = ecnt[CW0-1:0];
      e.all = (ecnt == W0);
      e.tag = t;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: pops the scoreboard on every output handshake and checks stalls hold.
  bit             hold = 1'b0;
  logic [CW0-1:0] h_cnt;
  logic           h_all;
  logic [3:0]     h_tag;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (hold) begin
        n_chk++;
        if (!out_valid || out_cnt !== h_cnt || out_all !== h_all || out_tag !== h_tag) begin
          n_fail++;
          $display("FAIL hold_stable got v%0b c%0d a%0b t%0d expected v1 c%0d a%0b t%0d",
                   out_valid, out_cnt, out_all, out_tag, h_cnt, h_all, h_tag);
        end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output c%0d t%0d with nothing outstanding", out_cnt, out_tag);
        end else begin
          e = sbq.pop_front();
          if (out_cnt !== e.cnt || out_all !== e.all || out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL result got c%0d a%0b t%0d expected c%0d a%0b t%0d",
                     out_cnt, out_all, out_tag, e.cnt, e.all, e.tag);
          end
        end
      end
      hold  = out_valid & ~out_ready;
      h_cnt = out_cnt; h_all = out_all; h_tag = out_tag;
    end else begin
      hold = 1'b0;
    end
  end

  // Pseudo-random consumer backpressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Other builds: one transaction at a time, checking latency and result.
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W  = (g == 3) ? 4 : 32;
    localparam int S  = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : 1;
    localparam int CW = $clog2(W) + 1;
    logic          c_rst_n, c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_all;
    logic [W-1:0]  c_in_data;
    logic [3:0]    c_in_tag, c_out_tag;
    logic [CW-1:0] c_out_cnt;

    lzc_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(4)) u_dut (
      .clk(clk), .rst_n(c_rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .in_mode(c_in_mode), .in_tag(c_in_tag),
      .out_valid(c_out_valid), .out_ready(1'b1), .out_cnt(c_out_cnt),
      .out_all(c_out_all), .out_tag(c_out_tag)
    );

    initial begin
      logic [31:0] r, d;
      logic        m;
      int          e, lat;
      c_rst_n = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_in_mode = 1'b0; c_in_tag = 4'd0;
      repeat (2) @(posedge clk);
      #1 c_rst_n = 1'b1;
      for (int j = 0; j < 12; j++) begin
        m = 1'($urandom_range(0, 1));
        r = $urandom >> $urandom_range(0, W);
        d = m ? ~r : r;
        if (j == 0) begin d = '0; m = 1'b0; end
        if (j == 1) begin d = '1; m = 1'b1; end
        e = ref_lzc({32'd0, d}, m, W);
        c_in_valid = 1'b1; c_in_data = d[W-1:0]; c_in_mode = m; c_in_tag = 4'(j);
        @(negedge clk);
        check($sformatf("cfg%0d_in_ready", g), int'(c_in_ready), 1);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!c_out_valid && lat < 40) begin
          lat++;
          @(negedge clk);
        end
        check($sformatf("cfg%0d_latency", g), lat, S);
        check($sformatf("cfg%0d_cnt", g), int'(c_out_cnt), e);
        check($sformatf("cfg%0d_all", g), int'(c_out_all), int'(e == W));
        check($sformatf("cfg%0d_tag", g), int'(c_out_tag), j % 16);
        @(posedge clk); #1;
      end
      cfg_done++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w, stalls, lat;
    logic [31:0] r, d;
    logic        m;
    exp_t        e;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = 4'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_cnt", int'(out_cnt), 0);
    check("rst_out_all", int'(out_all), 0);
    check("rst_out_tag", int'(out_tag), 0);
    check("rst_in_ready_low", int'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Directed values with the consumer always ready.
    out_ready = 1'b1;
    send(32'h0000_8000, 1'b0, 4'd3, 16, w);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    check("latency", lat, S0);
    @(posedge clk); #1;
    send(32'h0000_0000, 1'b0, 4'd4, 32, w);
    send(32'hFFFF_FFFF, 1'b1, 4'd5, 32, w);
    send(32'h8000_0000, 1'b0, 4'd6, 0, w);
    send(32'hF000_0000, 1'b1, 4'd7, 4, w);
    send(32'hF000_0000, 1'b0, 4'd8, 0, w);
    send(32'h0000_0001, 1'b0, 4'd9, 31, w);
    send(32'h7FFF_FFFF, 1'b1, 4'd10, 0, w);
    drain();

    // Full-rate burst: every offer should be taken on its first cycle.
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      m = 1'($urandom_range(0, 1));
      r = $urandom >> $urandom_range(0, 32);
      d = m ? ~r : r;
      send(d, m, 4'(i), ref_lzc({32'd0, d}, m, W0), w);
      stalls += w;
    end
    check("full_rate_stalls", stalls, 0);
    drain();

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      m = 1'($urandom_range(0, 1));
      r = $urandom >> $urandom_range(0, 32);
      d = m ? ~r : r;
      send(d, m, 4'(i), ref_lzc({32'd0, d}, m, W0), w);
    end
    rand_rdy = 1'b0;
    #2;
    out_ready = 1'b1;
    drain();

    // Stall: fill every slot, third offer must wait, ready returns with out_ready.
    out_ready = 1'b0;
    for (int i = 0; i < S0; i++) send(32'h00F0_0000 >> i, 1'b0, 4'(11 + i), 8 + i, w);
    in_valid = 1'b1; in_data = 32'h0000_0100; in_mode = 1'b0; in_tag = 4'd14;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready_low", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_same_cycle", int'(in_ready), 1);
    e.cnt = 6'd23; e.all = 1'b0; e.tag = 4'd14;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset with transactions in flight: nothing may emerge afterwards.
    out_ready = 1'b0;
    send(32'h0001_0000, 1'b0, 4'd12, 15, w);
    send(32'hFFF0_0000, 1'b1, 4'd13, 12, w);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("midrst_in_ready_low", int'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_cnt", int'(out_cnt), 0);
    check("midrst_out_all", int'(out_all), 0);
    check("midrst_out_tag", int'(out_tag), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    for (int i = 0; i < 2000 && cfg_done < 4; i++) @(posedge clk);
    check("cfg_blocks_done", cfg_done, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
